// File: rtl/uart_fifo_param.sv
// Parametrised single-clock FIFO for the APB UART RX/TX buffers.
// Synchronous-read RAM plus registered DATA_OUT; optional first-word-fall-through.
module uart_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 192,
    parameter int AEMPTY_TH = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WRB,
    input  logic              RDB,
    input  logic [WIDTH-1:0]  DATA_IN,
    input  logic              FLUSH,
    input  logic              CLR_ERR,
    output logic [WIDTH-1:0]  DATA_OUT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [WIDTH-1:0]  dout_q;
    logic              ovf_q;
    logic              unf_q;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_adv;

    assign full   = (count == DEPTH_C);
    assign wr_acc = !WRB && !full  && !FLUSH;
    assign rd_acc = !RDB && !empty && !FLUSH;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (FLUSH) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Errors are suppressed under FLUSH; a new error wins over CLR_ERR.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !CLR_ERR) || (!WRB && full  && !FLUSH);
            unf_q <= (unf_q && !CLR_ERR) || (!RDB && empty && !FLUSH);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) mem[wr_ptr] <= DATA_IN;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic out_valid;
            logic ram_has;
            logic ld;
            logic byp;

            // RAM words exclude the one already held in the output register.
            assign ram_has = (count > {{ADDR_W{1'b0}}, out_valid});
            assign ld      = !FLUSH && ram_has && (!out_valid || rd_acc);
            // Pop of the last word with a concurrent write: forward DATA_IN to avoid a bubble.
            assign byp     = rd_acc && wr_acc && !ram_has;
            assign rd_adv  = ld || byp;
            assign empty   = !out_valid;

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    out_valid <= 1'b0;
                    dout_q    <= '0;
                end else begin
                    if (FLUSH) begin
                        out_valid <= 1'b0;
                    end else if (ld || byp) begin
                        out_valid <= 1'b1;
                    end else if (rd_acc) begin
                        out_valid <= 1'b0;
                    end
                    if (ld) begin
                        dout_q <= mem[rd_ptr];
                    end else if (byp) begin
                        dout_q <= DATA_IN;
                    end
                end
            end
        end else begin : g_std
            logic [WIDTH-1:0] ram_q;
            logic             rd_pend;

            assign rd_adv = rd_acc;
            assign empty  = (count == '0);

            always_ff @(posedge CLK) begin
                if (rd_acc) ram_q <= mem[rd_ptr];
            end

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    rd_pend <= 1'b0;
                    dout_q  <= '0;
                end else begin
                    rd_pend <= rd_acc;
                    if (rd_pend) dout_q <= ram_q;
                end
            end
        end
    endgenerate

    assign DATA_OUT  = dout_q;
    assign FULL      = full;
    assign EMPTY     = empty;
    assign AFULL     = (count >= AFULL_C);
    assign AEMPTY    = (count <= AEMPTY_C);
    assign COUNT     = count;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: standard-mode and FWFT instances, depth 8, thresholds 6/1.
module tb_uart_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       s_wrb = 1'b1, s_rdb = 1'b1, s_flush = 1'b0, s_clr = 1'b0;
    logic [7:0] s_din = '0;
    logic [7:0] s_dout;
    logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [3:0] s_count;

    logic       f_wrb = 1'b1, f_rdb = 1'b1, f_flush = 1'b0, f_clr = 1'b0;
    logic [7:0] f_din = '0;
    logic [7:0] f_dout;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [3:0] f_count;

    int         checks = 0;
    int         errors = 0;
    int         s_cnt = 0;
    int         f_cnt = 0;
    logic [7:0] s_sb[$];
    logic [7:0] f_sb[$];
    logic [7:0] exp;

    always #5 clk = ~clk;

    uart_fifo_param #(.WIDTH(8), .ADDR_W(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) dut_s (
        .CLK(clk), .RESET_N(rst_n), .WRB(s_wrb), .RDB(s_rdb), .DATA_IN(s_din),
        .FLUSH(s_flush), .CLR_ERR(s_clr), .DATA_OUT(s_dout), .FULL(s_full),
        .EMPTY(s_empty), .AFULL(s_afull), .AEMPTY(s_aempty), .COUNT(s_count),
        .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
    );

    uart_fifo_param #(.WIDTH(8), .ADDR_W(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) dut_f (
        .CLK(clk), .RESET_N(rst_n), .WRB(f_wrb), .RDB(f_rdb), .DATA_IN(f_din),
        .FLUSH(f_flush), .CLR_ERR(f_clr), .DATA_OUT(f_dout), .FULL(f_full),
        .EMPTY(f_empty), .AFULL(f_afull), .AEMPTY(f_aempty), .COUNT(f_count),
        .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
    );

    // One clock of stimulus on the standard instance; accepted writes go to the scoreboard.
    task automatic cyc_s(input logic wrb, input logic rdb, input logic [7:0] din,
                         input logic fl, input logic cl);
        bit wa, ra;
        s_wrb = wrb; s_rdb = rdb; s_din = din; s_flush = fl; s_clr = cl;
        wa = !wrb && (s_cnt < 8);
        ra = !rdb && (s_cnt > 0);
        @(posedge clk); #1;
        if (fl) begin
            s_cnt = 0;
            s_sb.delete();
        end else begin
            if (wa) begin s_sb.push_back(din); s_cnt++; end
            if (ra) s_cnt--;
        end
        s_wrb = 1'b1; s_rdb = 1'b1; s_flush = 1'b0; s_clr = 1'b0;
    endtask

    // FWFT instance: the head of the scoreboard is what DATA_OUT must show.
    task automatic cyc_f(input logic wrb, input logic rdb, input logic [7:0] din,
                         input logic fl, input logic cl);
        bit wa, ra;
        f_wrb = wrb; f_rdb = rdb; f_din = din; f_flush = fl; f_clr = cl;
        wa = !wrb && (f_cnt < 8);
        ra = !rdb && (f_cnt > 0);
        @(posedge clk); #1;
        if (fl) begin
            f_cnt = 0;
            f_sb.delete();
        end else begin
            if (ra) begin void'(f_sb.pop_front()); f_cnt--; end
            if (wa) begin f_sb.push_back(din); f_cnt++; end
        end
        f_wrb = 1'b1; f_rdb = 1'b1; f_flush = 1'b0; f_clr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (s_empty !== 1'b1 || s_full !== 1'b0 || s_aempty !== 1'b1 || s_afull !== 1'b0) begin errors++; $display("FAIL reset_flags_s: got e%b f%b ae%b af%b want e1 f0 ae1 af0", s_empty, s_full, s_aempty, s_afull); end
        checks++; if (s_count !== 4'd0 || s_dout !== 8'h00 || s_ovf !== 1'b0 || s_unf !== 1'b0) begin errors++; $display("FAIL reset_state_s: got cnt %0d dout %h ovf %b unf %b want 0 00 0 0", s_count, s_dout, s_ovf, s_unf); end
        checks++; if (f_empty !== 1'b1 || f_count !== 4'd0 || f_dout !== 8'h00) begin errors++; $display("FAIL reset_state_f: got e%b cnt %0d dout %h want e1 0 00", f_empty, f_count, f_dout); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_empty !== 1'b1 || s_count !== 4'd0) begin errors++; $display("FAIL reset_release_s: got e%b cnt %0d want e1 0", s_empty, s_count); end
    endtask

    task automatic test_basic();
        logic [7:0] wdata [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            cyc_s(1'b0, 1'b1, wdata[i], 1'b0, 1'b0);
            checks++; if (s_count !== 4'(i + 1) || s_empty !== 1'b0) begin errors++; $display("FAIL basic_wr_count: got %0d e%b want %0d e0", s_count, s_empty, i + 1); end
        end
        for (int i = 0; i <= 3; i++) begin
            cyc_s(1'b1, (i < 3) ? 1'b0 : 1'b1, 8'h00, 1'b0, 1'b0);
            checks++; if (s_count !== 4'(2 - ((i < 3) ? i : 2))) begin errors++; $display("FAIL basic_rd_count: got %0d want %0d", s_count, 2 - ((i < 3) ? i : 2)); end
            if (i > 0) begin
                exp = s_sb.pop_front();
                checks++; if (s_dout !== exp) begin errors++; $display("FAIL basic_rd_data: got %h want %h", s_dout, exp); end
            end
        end
        checks++; if (s_empty !== 1'b1 || s_unf !== 1'b0) begin errors++; $display("FAIL basic_end: got e%b unf%b want e1 unf0", s_empty, s_unf); end
    endtask

    task automatic test_thresholds();
        for (int i = 0; i < 8; i++) begin
            cyc_s(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
            checks++; if (s_count !== 4'(i + 1)) begin errors++; $display("FAIL thr_count: got %0d want %0d", s_count, i + 1); end
            checks++; if (s_aempty !== ((i + 1) <= 1) || s_afull !== ((i + 1) >= 6) || s_full !== ((i + 1) == 8)) begin errors++; $display("FAIL thr_flags at %0d: got ae%b af%b f%b", i + 1, s_aempty, s_afull, s_full); end
        end
        cyc_s(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (s_count !== 4'd8 || s_ovf !== 1'b1) begin errors++; $display("FAIL thr_overflow: got cnt %0d ovf %b want 8 1", s_count, s_ovf); end
        cyc_s(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL thr_clr_err: got ovf %b want 0", s_ovf); end
        for (int i = 0; i <= 8; i++) begin
            cyc_s(1'b1, (i < 8) ? 1'b0 : 1'b1, 8'h00, 1'b0, 1'b0);
            if (i > 0) begin
                exp = s_sb.pop_front();
                checks++; if (s_dout !== exp) begin errors++; $display("FAIL thr_drain: got %h want %h", s_dout, exp); end
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) cyc_s(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i <= 6; i++) begin
            cyc_s(1'b1, (i < 6) ? 1'b0 : 1'b1, 8'h00, 1'b0, 1'b0);
            if (i > 0) begin
                exp = s_sb.pop_front();
                checks++; if (s_dout !== exp) begin errors++; $display("FAIL wrap_pre: got %h want %h", s_dout, exp); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc_s(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            checks++; if (s_full !== (i == 7)) begin errors++; $display("FAIL wrap_full at %0d: got %b want %b", i + 1, s_full, i == 7); end
        end
        for (int i = 0; i <= 8; i++) begin
            cyc_s(1'b1, (i < 8) ? 1'b0 : 1'b1, 8'h00, 1'b0, 1'b0);
            if (i > 0) begin
                exp = s_sb.pop_front();
                checks++; if (s_dout !== exp) begin errors++; $display("FAIL wrap_data: got %h want %h", s_dout, exp); end
            end
        end
        checks++; if (s_empty !== 1'b1 || s_count !== 4'd0) begin errors++; $display("FAIL wrap_end: got e%b cnt %0d want e1 0", s_empty, s_count); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) cyc_s(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc_s(1'b0, 1'b0, 8'h50 + 8'(i), 1'b0, 1'b0);
            checks++; if (s_count !== 4'd4) begin errors++; $display("FAIL simul_count: got %0d want 4", s_count); end
            if (i > 0) begin
                exp = s_sb.pop_front();
                checks++; if (s_dout !== exp) begin errors++; $display("FAIL simul_data: got %h want %h", s_dout, exp); end
            end
        end
        for (int i = 0; i <= 4; i++) begin
            cyc_s(1'b1, (i < 4) ? 1'b0 : 1'b1, 8'h00, 1'b0, 1'b0);
            exp = s_sb.pop_front();
            checks++; if (s_dout !== exp) begin errors++; $display("FAIL simul_drain: got %h want %h", s_dout, exp); end
        end
        cyc_s(1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        checks++; if (s_unf !== 1'b1 || s_count !== 4'd1 || s_empty !== 1'b0) begin errors++; $display("FAIL simul_empty: got unf %b cnt %0d e%b want 1 1 0", s_unf, s_count, s_empty); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) cyc_s(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        cyc_s(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (s_ovf !== 1'b1 || s_count !== 4'd8) begin errors++; $display("FAIL flush_setup: got ovf %b cnt %0d want 1 8", s_ovf, s_count); end
        for (int i = 0; i <= 3; i++) begin
            cyc_s(1'b1, (i < 3) ? 1'b0 : 1'b1, 8'h00, 1'b0, 1'b0);
            if (i > 0) begin
                exp = s_sb.pop_front();
                checks++; if (s_dout !== exp) begin errors++; $display("FAIL flush_pre_rd: got %h want %h", s_dout, exp); end
            end
        end
        checks++; if (s_count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d want 5", s_count); end
        cyc_s(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
        checks++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_ovf !== 1'b1 || s_unf !== 1'b1) begin errors++; $display("FAIL flush_state: got cnt %0d e%b ovf%b unf%b want 0 1 1 1", s_count, s_empty, s_ovf, s_unf); end
        checks++; if (s_dout !== exp) begin errors++; $display("FAIL flush_dout_hold: got %h want %h", s_dout, exp); end
        cyc_s(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
        cyc_s(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc_s(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        exp = s_sb.pop_front();
        checks++; if (s_dout !== exp || s_empty !== 1'b1) begin errors++; $display("FAIL flush_after: got %h e%b want %h e1", s_dout, s_empty, exp); end
        checks++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin errors++; $display("FAIL flush_clr_err: got ovf%b unf%b want 0 0", s_ovf, s_unf); end
    endtask

    task automatic test_fwft_basic();
        cyc_f(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b1 || f_count !== 4'd1) begin errors++; $display("FAIL fwft_edge_k: got e%b cnt %0d want e1 1", f_empty, f_count); end
        cyc_f(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b0 || f_dout !== f_sb[0]) begin errors++; $display("FAIL fwft_edge_k1: got e%b %h want e0 %h", f_empty, f_dout, f_sb[0]); end
        cyc_f(1'b0, 1'b1, 8'h5B, 1'b0, 1'b0);
        checks++; if (f_dout !== f_sb[0] || f_count !== 4'd2) begin errors++; $display("FAIL fwft_hold: got %h cnt %0d want %h 2", f_dout, f_count, f_sb[0]); end
        cyc_f(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b0 || f_dout !== f_sb[0]) begin errors++; $display("FAIL fwft_no_bubble: got e%b %h want e0 %h", f_empty, f_dout, f_sb[0]); end
        cyc_f(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b1 || f_count !== 4'd0) begin errors++; $display("FAIL fwft_empty: got e%b cnt %0d want e1 0", f_empty, f_count); end
    endtask

    task automatic test_fwft_stream();
        for (int i = 0; i < 4; i++) cyc_f(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        cyc_f(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (f_dout !== f_sb[0] || f_count !== 4'(4 - i)) begin errors++; $display("FAIL fwft_stream: got %h cnt %0d want %h %0d", f_dout, f_count, f_sb[0], 4 - i); end
            cyc_f(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_stream_end: got e%b want e1", f_empty); end
    endtask

    task automatic test_fwft_simultaneous();
        cyc_f(1'b0, 1'b1, 8'h61, 1'b0, 1'b0);
        cyc_f(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc_f(1'b0, 1'b0, 8'h62 + 8'(i), 1'b0, 1'b0);
            checks++; if (f_empty !== 1'b0 || f_count !== 4'd1 || f_dout !== f_sb[0]) begin errors++; $display("FAIL fwft_simul: got e%b cnt %0d %h want e0 1 %h", f_empty, f_count, f_dout, f_sb[0]); end
        end
        cyc_f(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b1 || f_unf !== 1'b0) begin errors++; $display("FAIL fwft_simul_end: got e%b unf%b want e1 unf0", f_empty, f_unf); end
        cyc_f(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (f_unf !== 1'b1 || f_count !== 4'd0) begin errors++; $display("FAIL fwft_underflow: got unf%b cnt %0d want 1 0", f_unf, f_count); end
    endtask

    task automatic test_reset_mid();
        cyc_s(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (s_unf !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got unf %b want 1", s_unf); end
        for (int i = 0; i < 3; i++) cyc_s(1'b0, 1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
        s_wrb = 1'b0; s_din = 8'h34;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_full !== 1'b0 || s_afull !== 1'b0 || s_aempty !== 1'b1) begin errors++; $display("FAIL rstmid_s_flags: got cnt %0d e%b f%b af%b ae%b want 0 1 0 0 1", s_count, s_empty, s_full, s_afull, s_aempty); end
        checks++; if (s_dout !== 8'h00 || s_ovf !== 1'b0 || s_unf !== 1'b0) begin errors++; $display("FAIL rstmid_s_data: got %h ovf%b unf%b want 00 0 0", s_dout, s_ovf, s_unf); end
        checks++; if (f_unf !== 1'b0 || f_empty !== 1'b1 || f_dout !== 8'h00) begin errors++; $display("FAIL rstmid_f: got unf%b e%b %h want 0 1 00", f_unf, f_empty, f_dout); end
        s_wrb = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        s_cnt = 0; s_sb.delete(); f_cnt = 0; f_sb.delete();
        #1;
        cyc_s(1'b0, 1'b1, 8'h21, 1'b0, 1'b0);
        checks++; if (s_count !== 4'd1) begin errors++; $display("FAIL rstmid_first_wr: got cnt %0d want 1", s_count); end
        cyc_s(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc_s(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        exp = s_sb.pop_front();
        checks++; if (s_dout !== exp || s_empty !== 1'b1) begin errors++; $display("FAIL rstmid_first_rd: got %h e%b want %h e1", s_dout, s_empty, exp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_thresholds();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_fwft_basic();
        test_fwft_stream();
        test_fwft_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
